regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Regfile write-side bus: source A writeback, source B valid/ready handshake,
// decode scoreboard query and the registered regfile write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
);
  logic          a_valid;
  logic [AW-1:0] a_reg;
  logic [W-1:0]  a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_reg;
  logic [W-1:0]  b_data;
  logic [AW-1:0] chk_reg;
  logic          chk_hit;
  logic          w;
  logic [AW-1:0] W_Reg;
  logic [W-1:0]  W_Data;

  // Producer / decode side
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, chk_reg,
    input  b_ready, chk_hit, w, W_Reg, W_Data
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, chk_reg,
    output b_ready, chk_hit, w, W_Reg, W_Data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write arbiter: source A (in-order writeback) has strict priority over
// source B, which is buffered in a DEPTH-entry FIFO. Writes to register 0 are
// dropped. chk_hit reports writes still pending in the FIFO or output stage.
// Optional macro WB_WAW_KILL_EN: an accepted A write kills older queued B
// entries to the same register; killed entries drain without writing.
module regfile_wb_arbiter #(
  parameter int unsigned W     = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [AW-1:0]    r_reg  [DEPTH];
  logic [W-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_w;
  logic [AW-1:0]    r_w_reg;
  logic [W-1:0]     r_w_data;
`ifdef WB_WAW_KILL_EN
  logic [DEPTH-1:0] r_kill;
`endif

  logic             w_b_ready;
  logic             w_enq;
  logic             w_a_go;
  logic             w_pop;
  logic             w_head_kill;
  logic [DEPTH-1:0] w_live;
  logic             w_fifo_hit;

  // Ready depends only on the registered count; a pop does not free a slot early
  assign w_b_ready = rst_n && (r_count != DepthC);
  assign w_enq     = bus.b_valid && w_b_ready && (bus.b_reg != '0);
  assign w_a_go    = bus.a_valid && (bus.a_reg != '0);
  assign w_pop     = !w_a_go && (r_count != '0);

`ifdef WB_WAW_KILL_EN
  assign w_live      = r_vld & ~r_kill;
  assign w_head_kill = r_kill[r_rd_ptr];
`else
  assign w_live      = r_vld;
  assign w_head_kill = 1'b0;
`endif

  // Live-entry match against the decode query
  always_comb begin
    w_fifo_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i] && (r_reg[i] == bus.chk_reg)) w_fifo_hit = 1'b1;
    end
  end

  assign bus.b_ready = w_b_ready;
  assign bus.chk_hit = (bus.chk_reg != '0) &&
                       (w_fifo_hit || (r_w && (r_w_reg == bus.chk_reg)));
  assign bus.w       = r_w;
  assign bus.W_Reg   = r_w_reg;
  assign bus.W_Data  = r_w_data;

  // FIFO payload storage; validity is tracked separately so no reset is needed
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_reg[r_wr_ptr]  <= bus.b_reg;
      r_data[r_wr_ptr] <= bus.b_data;
    end
  end

  // FIFO control: pointers, count, entry valid (and kill) bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
`ifdef WB_WAW_KILL_EN
      r_kill   <= '0;
`endif
    end else begin
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
`ifdef WB_WAW_KILL_EN
      // Older entries to the register A is writing now would clobber it later
      for (int i = 0; i < DEPTH; i++) begin
        if (w_a_go && r_vld[i] && (r_reg[i] == bus.a_reg)) r_kill[i] <= 1'b1;
      end
`endif
      // Same-cycle push is younger than A, so it is enqueued unkilled
      if (w_enq) begin
        r_vld[r_wr_ptr] <= 1'b1;
`ifdef WB_WAW_KILL_EN
        r_kill[r_wr_ptr] <= 1'b0;
`endif
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Registered write port: A first, else FIFO head (silent if killed)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w      <= 1'b0;
      r_w_reg  <= '0;
      r_w_data <= '0;
    end else if (w_a_go) begin
      r_w      <= 1'b1;
      r_w_reg  <= bus.a_reg;
      r_w_data <= bus.a_data;
    end else if (w_pop && !w_head_kill) begin
      r_w      <= 1'b1;
      r_w_reg  <= r_reg[r_rd_ptr];
      r_w_data <= r_data[r_rd_ptr];
    end else begin
      r_w <= 1'b0;
    end
  end
endmodule
